subservient_uart_rx: RTL and testbench

Synthesisable, parametrised UART receiver for the subservient SoC. It replaces simulation-only serial decoding with a clocked receiver that has:
- a runtime-programmable bit period
- a configurable frame format (data bits, parity, stop bits)
- per-byte error flags
- a small receive FIFO with a valid/ready drain interface

It sits between the external `rx` pin and a CPU-side peripheral register interface, or a testbench monitor.

---
 rtl/subservient_uart_pkg.sv | 23 ++
 rtl/subservient_uart_rx_fifo.sv | 64 ++++++
 rtl/subservient_uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_subservient_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/subservient_uart_pkg.sv
// rtl/subservient_uart_pkg.sv - Shared types and constants for the subservient UART receiver
package subservient_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_HI
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/subservient_uart_rx_fifo.sv
// rtl/subservient_uart_rx_fifo.sv - Generic first-word-fall-through synchronous FIFO
module subservient_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("subservient_uart_rx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/subservient_uart_rx.sv
// rtl/subservient_uart_rx.sv - UART receiver with programmable bit period and receive FIFO
module subservient_uart_rx
    import subservient_uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_rx,
    output logic [7:0]       o_data,
    output logic             o_perr,
    output logic             o_ferr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun
);
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("subservient_uart_rx: DATA_BITS must be 5..8");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("subservient_uart_rx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("subservient_uart_rx: STOP_BITS must be 1 or 2");
    end
    if (DIV_W < 2) begin : g_bad_div_w
        $error("subservient_uart_rx: DIV_W must be at least 2");
    end

    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);

    logic             rx_meta;
    logic             rxs;
    rx_state_t        state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [7:0]       shreg, shreg_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic             perr_q, perr_n;
    logic             ferr_q, ferr_n;
    logic             sample;
    logic             par_exp;
    logic [DIV_W-1:0] start_load;
    logic             push;
    rx_entry_t        push_entry;
    rx_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rxs     <= rx_meta;
        end
    end

    assign sample  = (cnt == '0);
    assign par_exp = (PARITY == PAR_ODD) ? ~(^shreg) : ^shreg;
    // The load cycle itself counts, so the start sample lands div>>1 clocks after detect.
    assign start_load = (i_div >> 1) - CNT_ONE;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div_q;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        perr_n     = perr_q;
        ferr_n     = ferr_q;
        push       = 1'b0;
        push_entry = '0;
        if (state != ST_IDLE && state != ST_WAIT_HI && !sample) begin
            cnt_n = cnt - CNT_ONE;
        end
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    div_n     = i_div;
                    cnt_n     = start_load;
                    shreg_n   = '0;
                    bit_cnt_n = '0;
                    perr_n    = 1'b0;
                    ferr_n    = 1'b0;
                    state_n   = ST_START;
                end
            end
            ST_START: begin
                if (sample) begin
                    cnt_n   = div_q;
                    state_n = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    cnt_n            = div_q;
                    shreg_n[bit_cnt] = rxs;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_PAR: begin
                if (sample) begin
                    cnt_n   = div_q;
                    perr_n  = rxs ^ par_exp;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    cnt_n  = div_q;
                    ferr_n = ferr_q | ~rxs;
                    if (bit_cnt == LAST_STOP) begin
                        push       = 1'b1;
                        push_entry = '{ferr: ferr_n, perr: perr_q, data: shreg};
                        bit_cnt_n  = '0;
                        // A low final stop bit may be a break; wait for the line to recover.
                        state_n    = rxs ? ST_IDLE : ST_WAIT_HI;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (rxs) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            div_q     <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            div_q     <= div_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            perr_q    <= perr_n;
            ferr_q    <= ferr_n;
            o_overrun <= push && fifo_full && !pop;
        end
    end

    assign pop = o_valid && i_ready;

    subservient_uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(rx_entry_t))
    ) u_fifo (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .push   (push),
        .wr_data(push_entry),
        .pop    (pop),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign o_valid = !fifo_empty;
    assign o_data  = head.data;
    assign o_perr  = head.perr;
    assign o_ferr  = head.ferr;

endmodule

// File: tb/tb_subservient_uart_rx.sv
// tb/tb_subservient_uart_rx.sv - Scoreboard bench for the subservient UART receiver
module tb_subservient_uart_rx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] div;
    logic        rx0, rx1, rx2;
    logic        rdy0, rdy1, rdy2;
    logic [7:0]  d0, d1, d2;
    logic        p0, p1, p2, f0, f1, f2, v0, v1, v2, ov0, ov1, ov2;
    int          total = 0;
    int          bad = 0;
    int          ovr_cnt = 0;
    logic [9:0]  q0[$];
    logic [9:0]  q1[$];
    logic [9:0]  q2[$];

    always #5 clk = ~clk;

    subservient_uart_rx #(.DIV_W(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_div(div), .i_rx(rx0), .o_data(d0), .o_perr(p0),
        .o_ferr(f0), .o_valid(v0), .i_ready(rdy0), .o_overrun(ov0));
    subservient_uart_rx #(.DIV_W(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_div(div), .i_rx(rx1), .o_data(d1), .o_perr(p1),
        .o_ferr(f1), .o_valid(v1), .i_ready(rdy1), .o_overrun(ov1));
    subservient_uart_rx #(.DIV_W(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_div(div), .i_rx(rx2), .o_data(d2), .o_perr(p2),
        .o_ferr(f2), .o_valid(v2), .i_ready(rdy2), .o_overrun(ov2));

    function automatic logic [9:0] ent(input logic f, input logic p, input logic [7:0] d);
        return {f, p, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic b);
        case (sel)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame bits LSB first (start bit in bit 0); each bit lasts div+1 = 10 clocks.
    task automatic send(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(sel, bits[i]);
            idle(10);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && v0 && rdy0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dut0 unexpected entry: got=%0h want=none", {f0, p0, d0});
            end else begin
                check("dut0 entry", {f0, p0, d0}, q0.pop_front());
            end
        end
        if (rst_n && ov0) ovr_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && v1 && rdy1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1 unexpected entry: got=%0h want=none", {f1, p1, d1});
            end else begin
                check("dut1 entry", {f1, p1, d1}, q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && v2 && rdy2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL dut2 unexpected entry: got=%0h want=none", {f2, p2, d2});
            end else begin
                check("dut2 entry", {f2, p2, d2}, q2.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        div   = 16'd9;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        idle(3);
        check("reset valid", v0, 0);
        check("reset data", d0, 0);
        check("reset perr", p0, 0);
        check("reset ferr", f0, 0);
        check("reset overrun", ov0, 0);
        rst_n = 1'b1;
        idle(5);

        // 8N1 0x55: valid rises exactly 97 cycles after the falling edge
        q0.push_back(ent(1'b0, 1'b0, 8'h55));
        fork
            send(0, {1'b1, 8'h55, 1'b0}, 10);
            begin
                repeat (96) @(posedge clk);
                #1;
                check("valid before t+97", v0, 0);
                @(posedge clk); #1;
                check("valid at t+97", v0, 1);
                check("data at t+97", d0, 8'h55);
                @(posedge clk); #1;
                check("valid after pop", v0, 0);
            end
        join
        idle(20);

        // break: stop bit low then line held low for 50 bit times
        q0.push_back(ent(1'b1, 1'b0, 8'h81));
        send(0, {8'h81, 1'b0}, 9);
        set_rx(0, 1'b0);
        idle(510);
        set_rx(0, 1'b1);
        idle(30);
        q0.push_back(ent(1'b0, 1'b0, 8'h3C));
        send(0, {1'b1, 8'h3C, 1'b0}, 10);
        idle(20);

        // 3-clock glitch must not produce an entry
        set_rx(0, 1'b0);
        idle(3);
        set_rx(0, 1'b1);
        idle(30);
        check("glitch no entry", v0, 0);
        q0.push_back(ent(1'b0, 1'b0, 8'h12));
        send(0, {1'b1, 8'h12, 1'b0}, 10);
        idle(20);

        // overrun: five back-to-back frames into a 4-deep FIFO with no drain
        rdy0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) q0.push_back(ent(1'b0, 1'b0, 8'(i)));
            send(0, {1'b1, 8'(i), 1'b0}, 10);
        end
        idle(5);
        check("overrun pulses", ovr_cnt, 1);
        check("full valid", v0, 1);
        q0.push_back(ent(1'b0, 1'b0, 8'h06));
        fork
            send(0, {1'b1, 8'h06, 1'b0}, 10);
            begin
                repeat (96) @(posedge clk);
                #1;
                rdy0 = 1'b1;
                @(posedge clk); #1;
                rdy0 = 1'b0;
            end
        join
        idle(5);
        check("no overrun on push+pop full", ovr_cnt, 1);
        rdy0 = 1'b1;
        idle(10);
        check("drained valid", v0, 0);
        check("drained queue", q0.size(), 0);

        // even parity
        q1.push_back(ent(1'b0, 1'b1, 8'hA5));
        send(1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        q1.push_back(ent(1'b0, 1'b0, 8'hA5));
        send(1, {1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        q1.push_back(ent(1'b0, 1'b0, 8'h07));
        send(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        idle(20);

        // 7 data bits, odd parity, two stop bits
        q2.push_back(ent(1'b0, 1'b0, 8'h41));
        send(2, {2'b11, 1'b1, 7'h41, 1'b0}, 11);
        q2.push_back(ent(1'b0, 1'b1, 8'h41));
        send(2, {2'b11, 1'b0, 7'h41, 1'b0}, 11);
        q2.push_back(ent(1'b1, 1'b0, 8'h2A));
        send(2, {2'b01, 1'b0, 7'h2A, 1'b0}, 11);
        set_rx(2, 1'b1);
        idle(30);

        // reset in the middle of a frame with an entry still buffered
        rdy0 = 1'b0;
        send(0, {1'b1, 8'h99, 1'b0}, 10);
        idle(5);
        check("buffered before reset", v0, 1);
        send(0, {3'b111, 1'b0}, 4);
        rst_n = 1'b0;
        #1;
        check("async reset valid", v0, 0);
        check("async reset data", d0, 0);
        check("async reset perr", p0, 0);
        check("async reset ferr", f0, 0);
        check("async reset overrun", ov0, 0);
        q0.delete();
        set_rx(0, 1'b1);
        idle(3);
        rst_n = 1'b1;
        idle(150);
        check("no entry after reset", v0, 0);
        rdy0 = 1'b1;
        q0.push_back(ent(1'b0, 1'b0, 8'hC3));
        send(0, {1'b1, 8'hC3, 1'b0}, 10);
        idle(20);

        check("q0 empty", q0.size(), 0);
        check("q1 empty", q1.size(), 0);
        check("q2 empty", q2.size(), 0);
        check("final overrun count", ovr_cnt, 1);
        check("dut1 idle valid", v1, 0);
        check("dut2 idle valid", v2, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
